packetizer: RTL

- Upstream neighbour of the de-packetizer.
- Converts a stream of 16-bit data words plus a last marker into 48-bit NoC flits. Each word becomes exactly one flit, typed HEAD, BODY, TAIL or HEAD_TAIL.
- Header fields (destination, source, word index, packet sequence) are inserted into every flit.
- A single output register with valid/ready backpressure drives the `flitoutde` link.

---
 rtl/noc_pkg.sv | 45 ++++
 rtl/flit_out_reg.sv | 44 ++++
 rtl/packetizer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the packetizer and the de-packetizer.
// Provides the flit width, flit-type encodings, field bit positions, the packed flit layout
// and a helper that folds a 16-bit word into the 8-bit checksum contribution.
package noc_pkg;

  localparam int unsigned FLIT_W = 48;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FLIT_BODY      = 2'b00;
  localparam flit_type_t FLIT_HEAD      = 2'b01;
  localparam flit_type_t FLIT_TAIL      = 2'b10;
  localparam flit_type_t FLIT_HEAD_TAIL = 2'b11;

  // Field bit positions within a flit
  localparam int unsigned TYPE_MSB    = 47;
  localparam int unsigned TYPE_LSB    = 46;
  localparam int unsigned DEST_MSB    = 45;
  localparam int unsigned DEST_LSB    = 42;
  localparam int unsigned SRC_MSB     = 41;
  localparam int unsigned SRC_LSB     = 38;
  localparam int unsigned IDX_MSB     = 37;
  localparam int unsigned IDX_LSB     = 32;
  localparam int unsigned SEQ_MSB     = 31;
  localparam int unsigned SEQ_LSB     = 24;
  localparam int unsigned CSUM_MSB    = 23;
  localparam int unsigned CSUM_LSB    = 16;
  localparam int unsigned PAYLOAD_MSB = 15;
  localparam int unsigned PAYLOAD_LSB = 0;

  typedef struct packed {
    flit_type_t  ftype;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [5:0]  idx;
    logic [7:0]  seq;
    logic [7:0]  csum;
    logic [15:0] payload;
  } flit_t;

  function automatic logic [7:0] word_xor(input logic [15:0] word);
    return word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry valid/ready output register.
// Loads data_i when load_i is high, holds contents while the consumer stalls, and drops
// valid once the entry is taken without a replacement.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load_i      - write data_i into the register this cycle
//   data_i      - next contents
//   ready_i     - consumer accepts the current entry
//   valid_o     - register holds a valid entry
//   data_o      - register contents
//   in_ready_o  - register can take a new entry this cycle (empty or draining)
module flit_out_reg #(
  parameter int unsigned Width = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             in_ready_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/packetizer.sv
// Packetizer: turns a stream of 16-bit words with a last marker into 48-bit NoC flits,
// one flit per word, typed HEAD / BODY / TAIL / HEAD_TAIL with routing header fields.
// Optional macro PACKETIZER_CHECKSUM_EN adds an XOR checksum in flit bits [23:16] of the
// final flit of each packet; without it those bits are zero.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   data_in     - payload word
//   data_valid  - data_in valid
//   data_last   - data_in is the last word of its packet
//   dest_id     - destination node, sampled on the first word of a packet
//   data_ready  - word accepted this cycle when data_valid is high
//   flitoutde   - flit towards the de-packetizer
//   flit_valid  - flitoutde valid
//   flit_ready  - downstream accepts the flit
module packetizer
  import noc_pkg::*;
#(
  parameter logic [3:0]  SRC_ID      = 4'h0,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       data_in,
  input  logic              data_valid,
  input  logic              data_last,
  input  logic [3:0]        dest_id,
  output logic              data_ready,
  output logic [FLIT_W-1:0] flitoutde,
  output logic              flit_valid,
  input  logic              flit_ready
);

  localparam logic [5:0] LastIdx = 6'(MAX_PKT_LEN - 1);

  typedef enum logic [0:0] {StIdle, StInPkt} state_e;

  state_e     state_q, state_d;
  logic [5:0] index_q, index_d;
  logic [7:0] seq_q, seq_d;
  logic [3:0] dest_q, dest_d;

  logic       accept;
  logic       is_first;
  logic       is_end;
  logic [5:0] cur_idx;
  logic [3:0] cur_dest;
  flit_t      flit_d;

`ifdef PACKETIZER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] csum_new;
`endif

  assign accept = data_valid && data_ready;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    seq_d    = seq_q;
    dest_d   = dest_q;

    is_first = (state_q == StIdle);
    cur_idx  = is_first ? 6'd0 : index_q + 6'd1;
    cur_dest = is_first ? dest_id : dest_q;
    // Covers both an explicit last marker and forced termination at the length limit;
    // with MAX_PKT_LEN == 1 the first word already matches LastIdx.
    is_end   = data_last || (cur_idx == LastIdx);

    flit_d         = '0;
    flit_d.dest    = cur_dest;
    flit_d.src     = SRC_ID;
    flit_d.idx     = cur_idx;
    flit_d.seq     = seq_q;
    flit_d.payload = data_in;
    if (is_first) begin
      flit_d.ftype = is_end ? FLIT_HEAD_TAIL : FLIT_HEAD;
    end else begin
      flit_d.ftype = is_end ? FLIT_TAIL : FLIT_BODY;
    end

`ifdef PACKETIZER_CHECKSUM_EN
    csum_d   = csum_q;
    csum_new = csum_q ^ word_xor(data_in);
    if (is_end) begin
      flit_d.csum = csum_new;
    end
`endif

    if (accept) begin
      dest_d = cur_dest;
      if (is_end) begin
        state_d = StIdle;
        index_d = 6'd0;
        seq_d   = seq_q + 8'd1;
      end else begin
        state_d = StInPkt;
        index_d = cur_idx;
      end
`ifdef PACKETIZER_CHECKSUM_EN
      csum_d = is_end ? 8'h00 : csum_new;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= 6'd0;
      seq_q   <= 8'd0;
      dest_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      seq_q   <= seq_d;
      dest_q  <= dest_d;
    end
  end

`ifdef PACKETIZER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  flit_out_reg #(
    .Width (FLIT_W)
  ) u_flit_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .data_i     (flit_d),
    .ready_i    (flit_ready),
    .valid_o    (flit_valid),
    .data_o     (flitoutde),
    .in_ready_o (data_ready)
  );

endmodule
